// File: rtl/keypad_pkg.sv
// Shared constants and types for the 12-key keypad front-end.
// Key bit map: 0-9 are the digit keys, 10 is '*', 11 is '#'.
package keypad_pkg;

  localparam int N_KEYS     = 12;

  localparam int KIDX_0     = 0;
  localparam int KIDX_1     = 1;
  localparam int KIDX_2     = 2;
  localparam int KIDX_3     = 3;
  localparam int KIDX_4     = 4;
  localparam int KIDX_5     = 5;
  localparam int KIDX_6     = 6;
  localparam int KIDX_7     = 7;
  localparam int KIDX_8     = 8;
  localparam int KIDX_9     = 9;
  localparam int KIDX_STAR  = 10;
  localparam int KIDX_SHARP = 11;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic hold_long;
  } key_evt_t;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, tick-based debounce and long-press hold counter.
// All four event outputs are registered; the shared tick comes from the parent.
module key_debounce_cell
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS   = 10,
  parameter int LONG_PRESS_TICKS = 1000
) (
  input  logic     CLK,
  input  logic     global_safe_rst,
  input  logic     tick,
  input  logic     key_raw,
  output key_evt_t evt
);

  localparam int DB_W   = cnt_width(DEBOUNCE_TICKS);
  localparam int HOLD_W = cnt_width(LONG_PRESS_TICKS);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [1:0]        sync_q, sync_d;
  logic              stable_q, stable_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

  // Any single cycle of agreement restarts the window, so short glitches leave no trace.
  always_comb begin
    sync_d   = {sync_q[0], key_raw};
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (sync_q[1] == stable_q) begin
      db_cnt_d = '0;
    end else if (tick) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync_q[1];
        db_cnt_d = '0;
        press_d  = sync_q[1];
        rel_d    = ~sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end
  end

  // Saturation at the limit is what keeps key_long to one pulse per hold.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    if (!stable_q) begin
      hold_cnt_d = '0;
    end else if (tick && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HOLD_ONE;
      long_d     = (hold_cnt_q == HOLD_LAST);
    end
  end

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      sync_q     <= '0;
      stable_q   <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
    end
  end

  assign evt = '{level: stable_q, press: press_q, rel: rel_q, hold_long: long_q};

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad front-end: shared debounce prescaler plus one conditioning cell per key.
// Never derive global_safe_rst from these outputs; that would form a reset loop.
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int TICK_DIV         = 50000,
  parameter int DEBOUNCE_TICKS   = 10,
  parameter int LONG_PRESS_TICKS = 1000
) (
  input  logic              CLK,
  input  logic              global_safe_rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              any_active
);

  localparam int TICK_W = cnt_width(TICK_DIV - 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic              any_active_q, any_active_d;
  key_evt_t          evt [N_KEYS];

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_ONE);
  end

  always_comb begin
    any_active_d = |key_level;
  end

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      tick_cnt_q   <= '0;
      any_active_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      any_active_q <= any_active_d;
    end
  end

  assign any_active = any_active_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
      .LONG_PRESS_TICKS(LONG_PRESS_TICKS)
    ) u_cell (
      .CLK            (CLK),
      .global_safe_rst(global_safe_rst),
      .tick           (tick),
      .key_raw        (key_raw[i]),
      .evt            (evt[i])
    );

    assign key_level[i]   = evt[i].level;
    assign key_press[i]   = evt[i].press;
    assign key_release[i] = evt[i].rel;
    assign key_long[i]    = evt[i].hold_long;
  end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Self-checking bench for keypad_conditioner: directed scenarios plus random key
// activity, checked every cycle against a tick-arithmetic reference model.
module tb_keypad_conditioner;
  import keypad_pkg::*;

  localparam int TDIV = 4;
  localparam int DB   = 3;
  localparam int LP   = 8;

  logic              CLK;
  logic              global_safe_rst;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic              any_active;

  keypad_conditioner #(
    .TICK_DIV        (TDIV),
    .DEBOUNCE_TICKS  (DB),
    .LONG_PRESS_TICKS(LP)
  ) dut (
    .CLK            (CLK),
    .global_safe_rst(global_safe_rst),
    .key_raw        (key_raw),
    .key_level      (key_level),
    .key_press      (key_press),
    .key_release    (key_release),
    .key_long       (key_long),
    .any_active     (any_active)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: edges counted from reset release; a tick falls on every
  // edge whose index is a multiple of TDIV. A key flips once DB ticks have
  // elapsed since the last edge on which its synchronised input agreed.
  int                n;
  logic [N_KEYS-1:0] m_level, m_press, m_release, m_long, h1, h2;
  logic              m_any;
  int                last_agree [N_KEYS];
  int                press_edge [N_KEYS];

  task automatic modelReset();
    n = 0;
    m_level = '0; m_press = '0; m_release = '0; m_long = '0;
    m_any = 1'b0; h1 = '0; h2 = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      last_agree[i] = 0;
      press_edge[i] = -100000;
    end
  endtask

  task automatic modelEdge();
    logic [N_KEYS-1:0] old_level;
    old_level = m_level;
    n++;
    m_any = |old_level;
    m_press = '0; m_release = '0; m_long = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (old_level[i] && (n - press_edge[i] == LP * TDIV)) m_long[i] = 1'b1;
      if (h2[i] == old_level[i]) begin
        last_agree[i] = n;
      end else if ((n % TDIV == 0) && ((n / TDIV) - (last_agree[i] / TDIV) == DB)) begin
        m_level[i] = h2[i];
        if (h2[i]) begin
          m_press[i] = 1'b1;
          press_edge[i] = n;
        end else begin
          m_release[i] = 1'b1;
        end
        last_agree[i] = n;
      end
    end
    h2 = h1;
    h1 = key_raw;
  endtask

  task automatic checkVec(input string tag, input logic [N_KEYS-1:0] obs, input logic [N_KEYS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s (edge %0d): observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic checkOutput();
    checkVec("level",   key_level,   m_level);
    checkVec("press",   key_press,   m_press);
    checkVec("release", key_release, m_release);
    checkVec("long",    key_long,    m_long);
    checkVec("any",     {{(N_KEYS-1){1'b0}}, any_active}, {{(N_KEYS-1){1'b0}}, m_any});
  endtask

  task automatic checkAllZero(input string tag);
    checkVec({tag, "_level"},   key_level,   '0);
    checkVec({tag, "_press"},   key_press,   '0);
    checkVec({tag, "_release"}, key_release, '0);
    checkVec({tag, "_long"},    key_long,    '0);
    checkVec({tag, "_any"},     {{(N_KEYS-1){1'b0}}, any_active}, '0);
  endtask

  // Drive one raw pattern for one clock and check every output at the falling edge.
  task automatic applyStimulus(input logic [N_KEYS-1:0] raw);
    key_raw = raw;
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
    checkOutput();
    cyc++;
  endtask

  task automatic resetMidRun(input string tag);
    #2 global_safe_rst = 1'b1;
    #1 checkAllZero(tag);
    @(negedge CLK);
    @(negedge CLK);
    global_safe_rst = 1'b0;
    modelReset();
  endtask

  logic [N_KEYS-1:0] raw;
  int press_cyc, long_cyc, rel_cyc, fall_cyc, start_cyc;
  int cnt_a, cnt_b, cnt_c;
  int p3_cyc, p9_cyc;
  logic both_same, any_after, lvl_low_seen;

  initial begin
    key_raw = '0;
    global_safe_rst = 1'b1;
    modelReset();
    repeat (3) @(negedge CLK);
    checkAllZero("por");
    global_safe_rst = 1'b0;

    // Clean press on key 0, held through the long-press point.
    raw = '0;
    raw[KIDX_0] = 1'b1;
    start_cyc = cyc; press_cyc = -1; long_cyc = -1; cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(raw);
      if (key_press[KIDX_0]) begin cnt_a++; if (press_cyc < 0) press_cyc = cyc; end
      if (key_long[KIDX_0])  begin cnt_b++; if (long_cyc < 0) long_cyc = cyc; end
    end
    checkRange("press0_latency", press_cyc - start_cyc, 11, 14);
    checkRange("press0_count", cnt_a, 1, 1);
    checkRange("long0_delay", long_cyc - press_cyc, 28, 36);
    checkRange("long0_count", cnt_b, 1, 1);
    raw = '0;
    repeat (20) applyStimulus(raw);

    // Bounce on '*': 7 cycles high never survives the window.
    raw[KIDX_STAR] = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 27; k++) begin
      if (k == 7) raw[KIDX_STAR] = 1'b0;
      applyStimulus(raw);
      if (key_press[KIDX_STAR]) cnt_a++;
      if (key_level[KIDX_STAR]) cnt_b++;
    end
    checkRange("bounce_press_count", cnt_a, 0, 0);
    checkRange("bounce_level_cycles", cnt_b, 0, 0);

    // '#' held 20 cycles then released: release pulse, no long press.
    raw[KIDX_SHARP] = 1'b1;
    cnt_a = 0; cnt_c = 0; rel_cyc = -1;
    repeat (20) begin
      applyStimulus(raw);
      if (key_press[KIDX_SHARP]) cnt_a++;
      if (key_long[KIDX_SHARP])  cnt_c++;
    end
    raw[KIDX_SHARP] = 1'b0;
    fall_cyc = cyc;
    cnt_b = 0;
    repeat (40) begin
      applyStimulus(raw);
      if (key_release[KIDX_SHARP]) begin cnt_b++; if (rel_cyc < 0) rel_cyc = cyc; end
      if (key_long[KIDX_SHARP]) cnt_c++;
    end
    checkRange("sharp_press_count", cnt_a, 1, 1);
    checkRange("sharp_release_latency", rel_cyc - fall_cyc, 11, 14);
    checkRange("sharp_release_count", cnt_b, 1, 1);
    checkRange("sharp_long_count", cnt_c, 0, 0);

    // Keys 3 and 9 rise together.
    raw[KIDX_3] = 1'b1; raw[KIDX_9] = 1'b1;
    start_cyc = cyc; p3_cyc = -1; p9_cyc = -1; both_same = 1'b0; any_after = 1'b0;
    repeat (20) begin
      applyStimulus(raw);
      if (key_press[KIDX_3] && p3_cyc < 0) p3_cyc = cyc;
      if (key_press[KIDX_9] && p9_cyc < 0) p9_cyc = cyc;
      if (key_press[KIDX_3] && key_press[KIDX_9]) both_same = 1'b1;
      if (p3_cyc >= 0 && cyc == p3_cyc + 1) any_after = any_active;
    end
    checkRange("p3_latency", p3_cyc - start_cyc, 11, 14);
    checkRange("p9_latency", p9_cyc - start_cyc, 11, 14);
    checkVec("simul_same_edge", {{(N_KEYS-1){1'b0}}, both_same}, 12'h001);
    checkVec("simul_any_next", {{(N_KEYS-1){1'b0}}, any_after}, 12'h001);
    raw = '0;
    repeat (20) applyStimulus(raw);

    // Key 7: brief drop inside the debounce window produces no event pair.
    raw[KIDX_7] = 1'b1;
    repeat (20) applyStimulus(raw);
    cnt_a = 0; cnt_b = 0; lvl_low_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      raw[KIDX_7] = !(k >= 2 && k < 5);
      applyStimulus(raw);
      if (key_press[KIDX_7])   cnt_a++;
      if (key_release[KIDX_7]) cnt_b++;
      if (!key_level[KIDX_7])  lvl_low_seen = 1'b1;
    end
    checkRange("repress_press_count", cnt_a, 0, 0);
    checkRange("repress_release_count", cnt_b, 0, 0);
    checkVec("repress_level_low", {{(N_KEYS-1){1'b0}}, lvl_low_seen}, '0);
    raw = '0;
    repeat (20) applyStimulus(raw);

    // Reset while key 5 is held: outputs clear at once, then a fresh press.
    raw[KIDX_5] = 1'b1;
    repeat (20) applyStimulus(raw);
    resetMidRun("midhold_rst");
    start_cyc = cyc; press_cyc = -1;
    repeat (20) begin
      applyStimulus(raw);
      if (key_press[KIDX_5] && press_cyc < 0) press_cyc = cyc;
    end
    checkRange("post_reset_press5", press_cyc - start_cyc, 11, 14);

    // Random activity on all keys, fast and slow regimes, with one reset.
    for (int k = 0; k < 1600; k++) begin
      for (int i = 0; i < N_KEYS; i++) begin
        if ((k / 400) % 2 == 0) begin
          if ($urandom_range(0, 7) == 0) raw[i] = ~raw[i];
        end else begin
          if ($urandom_range(0, 59) == 0) raw[i] = ~raw[i];
        end
      end
      applyStimulus(raw);
      if (k == 1000) resetMidRun("random_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_conditioner.md
# keypad_conditioner

Front-end for the 12-key keypad: synchronises, debounces and edge-classifies the raw key lines before the top-level vehicle logic consumes them. Outputs are a clean held level, single-cycle press/release pulses and a single-cycle long-press pulse per key. The top level's local `prev_key_*` edge registers become unnecessary. Sits between the keypad pins and the top-level ignition FSM, gear selector and brake/horn logic.

## Interface
- `N_KEYS`, 12, number of key lines. Bit map: 0–9 = KEY_0..KEY_9, 10 = KEY_STAR, 11 = KEY_SHARP.
- `TICK_DIV`, 50000, CLK cycles per debounce tick (1 ms at 50 MHz).
- `DEBOUNCE_TICKS`, 10, consecutive mismatching ticks required to accept a new level.
- `LONG_PRESS_TICKS`, 1000, held ticks before `key_long` fires.
- `CLK` in 1: system clock; all state on rising edge.
- `global_safe_rst` in 1: reset, asynchronous, active-high.
- `key_raw` in N_KEYS: asynchronous raw key pins, 1 = pressed.
- `key_level` out N_KEYS: debounced held state.
- `key_press` out N_KEYS: 1-cycle pulse on debounced 0→1.
- `key_release` out N_KEYS: 1-cycle pulse on debounced 1→0.
- `key_long` out N_KEYS: 1-cycle pulse once per hold when the hold reaches LONG_PRESS_TICKS.
- `any_active` out 1: OR of `key_level`.

## Operation
- Synchroniser: 2-flop chain per key, reset to 0; `sync` is the second flop.
- Prescaler:
  - Shared counter 0..TICK_DIV-1, wraps to 0.
  - `tick` is asserted in the cycle the counter equals TICK_DIV-1.
- Per-key debounce (`stable`, `db_cnt`, width clog2(DEBOUNCE_TICKS+1)):
  - `sync == stable` in any cycle → `db_cnt` ← 0. A glitch shorter than the window is fully discarded.
  - `sync != stable` and `tick` → `db_cnt` increments.
  - On the tick where the increment would reach DEBOUNCE_TICKS: `stable` ← `sync`, `db_cnt` ← 0, and the matching press/release pulse is registered on the same edge.
- Per-key hold counter (`hold_cnt`, width clog2(LONG_PRESS_TICKS+1)):
  - Cleared while `stable` = 0.
  - Increments on `tick` while `stable` = 1, saturating at LONG_PRESS_TICKS.
  - `key_long` pulses on the edge where it reaches LONG_PRESS_TICKS. It never repeats until a release followed by a new press.
- Keys are fully independent. Any combination can change or be held simultaneously.
- `key_level`, `key_press`, `key_release`, `key_long` and `any_active` are all registered. `any_active` is registered one cycle behind `key_level`.
- The top level must form `global_safe_rst` from raw or synchronised pins, never from this block's outputs; doing so creates a reset loop.

## Timing
- Reset (async assert, sync to next edge on release): every output 0; `stable`, `db_cnt`, `hold_cnt`, synchroniser and prescaler all 0.
- Raw edge → `sync`: 2 cycles.
- Raw edge → `key_level` change and pulse: 2 + (DEBOUNCE_TICKS-1)·TICK_DIV + φ cycles, with φ ∈ [1, TICK_DIV] set by prescaler phase.
- `key_press` and `key_level` rise on the same edge. `key_release` and the `key_level` fall likewise coincide.
- Press → `key_long`: LONG_PRESS_TICKS ticks after the `key_press` edge, ± prescaler phase.
- Reset mid-hold: outputs drop to 0 immediately. A key still held after reset release must re-debounce and produces a fresh `key_press`.
- Release before LONG_PRESS_TICKS: no `key_long`.

## Structure
- Package `keypad_pkg`:
  - index constants `KIDX_0`..`KIDX_9`, `KIDX_STAR`, `KIDX_SHARP`;
  - `N_KEYS`;
  - a width helper for the counters.
- Sub-module `key_debounce_cell`: one key's synchroniser, debounce and hold logic. It takes `tick` as an input and is instantiated N_KEYS times via generate. The prescaler stays in the parent.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_PRESS_TICKS=8.
- Reset: assert mid-run with key 5 held → all outputs 0 in the same cycle. After release, key 5 `key_press` arrives 11–14 cycles later.
- Clean press: `key_raw[0]` 0→1 at cycle 0 and held → `key_level[0]`=1 and a 1-cycle `key_press[0]` at cycle 11–14. `key_long[0]` pulses exactly once 32±4 cycles after that. No further pulses.
- Bounce rejection: `key_raw[10]` high for 7 cycles then low → no `key_press`, `key_level` stays 0.
- Release: hold key 11 for 20 cycles then release → `key_release[11]` 1 cycle at 11–14 cycles after the fall. No `key_long`.
- Simultaneous: keys 3 and 9 rise on the same cycle → both `key_press` pulses on the same edge, `any_active`=1 one cycle later.
- Re-press: release then press key 7 within the debounce window → no release/press pair emitted. `key_level[7]` stays 1.
